// File: rtl/rtp_hit_collector.sv
// Collects per-ray closest-hit results from the ray-tracing processor, keeps the
// minimum hitT per ray, tracks statistics and serves readback once collection is done.
module rtp_hit_collector #(
    parameter int          RAY_NUM    = 64,
    parameter logic [31:0] MISS_T     = 32'h7F800000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_valid,
    output logic        io_ready,
    input  logic [31:0] io_ray_id,
    input  logic [31:0] io_hitT,
    input  logic        io_rtp_finish,
    output logic        io_done,
    input  logic [31:0] io_rdAddr,
    output logic [31:0] io_rdData,
    output logic [31:0] io_ray_count,
    output logic [31:0] io_miss_count,
    output logic [31:0] io_dup_count,
    output logic        io_err_oob,
    output logic [63:0] io_cycles,
    output logic [1:0]  dbg_state
);

    localparam int IDX_W = $clog2(RAY_NUM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [31:0]    fifo_id  [FIFO_DEPTH];
    logic [31:0]    fifo_hit [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;

    logic [31:0]    slot [RAY_NUM];
    logic [RAY_NUM-1:0] written;

    logic           push, pop;
    logic [31:0]    head_id, head_hit, cur_hit;
    logic           head_oob;
    logic [IDX_W-1:0] head_idx;
    logic           rd_oob;

    // Handshake: a result transfers on a cycle where io_valid and io_ready are both
    // high; the producer holds io_ray_id/io_hitT stable while io_valid waits for io_ready.
    assign io_ready  = (count != (PTR_W+1)'(FIFO_DEPTH)) && (state != S_DONE);
    assign push      = io_valid && io_ready;
    assign pop       = (count != '0);
    assign io_done   = (state == S_DONE);
    assign dbg_state = state;

    assign head_id  = fifo_id[rd_ptr];
    assign head_hit = fifo_hit[rd_ptr];
    assign head_oob = (head_id >= 32'(RAY_NUM));
    assign head_idx = head_id[IDX_W-1:0];
    assign cur_hit  = slot[head_idx];
    assign rd_oob   = (io_rdAddr >= 32'(RAY_NUM));

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (io_rtp_finish)
                    state_next = S_DRAIN;
                else if (push)
                    state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (io_rtp_finish)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (count_next == '0)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_id[wr_ptr]  <= io_ray_id;
                fifo_hit[wr_ptr] <= io_hitT;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Commit the FIFO head; duplicates keep the smaller distance (unsigned compare
    // orders non-negative IEEE-754 singles correctly).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RAY_NUM; i++)
                slot[i] <= MISS_T;
            written       <= '0;
            io_ray_count  <= '0;
            io_miss_count <= '0;
            io_dup_count  <= '0;
            io_err_oob    <= 1'b0;
        end else if (pop) begin
            if (head_oob) begin
                io_err_oob <= 1'b1;
            end else if (!written[head_idx]) begin
                slot[head_idx]    <= head_hit;
                written[head_idx] <= 1'b1;
                io_ray_count      <= io_ray_count + 32'd1;
                if (head_hit == MISS_T)
                    io_miss_count <= io_miss_count + 32'd1;
            end else begin
                io_dup_count <= io_dup_count + 32'd1;
                if (head_hit < cur_hit) begin
                    slot[head_idx] <= head_hit;
                    if (cur_hit == MISS_T)
                        io_miss_count <= io_miss_count - 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            io_cycles <= '0;
        else if (state == S_COLLECT || state == S_DRAIN)
            io_cycles <= io_cycles + 64'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            io_rdData <= MISS_T;
        else
            io_rdData <= rd_oob ? MISS_T : slot[io_rdAddr[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_rtp_hit_collector.sv
// Directed testbench for rtp_hit_collector: reset state, fill, duplicates,
// out-of-range ids, empty finish and mid-stream reset.
module tb_rtp_hit_collector;

    localparam logic [31:0] MISS_T = 32'h7F800000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_valid = 1'b0;
    logic        io_ready;
    logic [31:0] io_ray_id = '0;
    logic [31:0] io_hitT = '0;
    logic        io_rtp_finish = 1'b0;
    logic        io_done;
    logic [31:0] io_rdAddr = '0;
    logic [31:0] io_rdData;
    logic [31:0] io_ray_count;
    logic [31:0] io_miss_count;
    logic [31:0] io_dup_count;
    logic        io_err_oob;
    logic [63:0] io_cycles;
    logic [1:0]  dbg_state;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    rtp_hit_collector dut (
        .clock         (clock),
        .reset         (reset),
        .io_valid      (io_valid),
        .io_ready      (io_ready),
        .io_ray_id     (io_ray_id),
        .io_hitT       (io_hitT),
        .io_rtp_finish (io_rtp_finish),
        .io_done       (io_done),
        .io_rdAddr     (io_rdAddr),
        .io_rdData     (io_rdData),
        .io_ray_count  (io_ray_count),
        .io_miss_count (io_miss_count),
        .io_dup_count  (io_dup_count),
        .io_err_oob    (io_err_oob),
        .io_cycles     (io_cycles),
        .dbg_state     (dbg_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        io_valid = 1'b0;
        io_rtp_finish = 1'b0;
        io_rdAddr = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] id, input logic [31:0] hit, input logic fin);
        io_valid = 1'b1;
        io_ray_id = id;
        io_hitT = hit;
        io_rtp_finish = fin;
    endtask

    task automatic clear_inputs();
        io_valid = 1'b0;
        io_rtp_finish = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (io_ready !== 1'b1) $display("FAIL rst_ready: got %0d expected 1", io_ready); else passed++;
        checks++; if (io_done !== 1'b0) $display("FAIL rst_done: got %0d expected 0", io_done); else passed++;
        checks++; if (io_rdData !== MISS_T) $display("FAIL rst_rddata: got %h expected %h", io_rdData, MISS_T); else passed++;
        checks++; if (io_ray_count !== 32'd0) $display("FAIL rst_ray: got %0d expected 0", io_ray_count); else passed++;
        checks++; if (io_miss_count !== 32'd0) $display("FAIL rst_miss: got %0d expected 0", io_miss_count); else passed++;
        checks++; if (io_dup_count !== 32'd0) $display("FAIL rst_dup: got %0d expected 0", io_dup_count); else passed++;
        checks++; if (io_err_oob !== 1'b0) $display("FAIL rst_oob: got %0d expected 0", io_err_oob); else passed++;
        checks++; if (io_cycles !== 64'd0) $display("FAIL rst_cycles: got %0d expected 0", io_cycles); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", dbg_state); else passed++;
    endtask

    // 64 back-to-back pushes, finish coincides with the last one.
    task automatic test_fill();
        apply_reset();
        for (int id = 0; id < 64; id++) begin
            set_push(32'(id), 32'h3F800000 + 32'(id), id == 63);
            tick();
        end
        clear_inputs();
        checks++; if (io_done !== 1'b0) $display("FAIL fill_done_early: got %0d expected 0", io_done); else passed++;
        tick();
        checks++; if (io_done !== 1'b1) $display("FAIL fill_done: got %0d expected 1", io_done); else passed++;
        checks++; if (io_ray_count !== 32'd64) $display("FAIL fill_ray: got %0d expected 64", io_ray_count); else passed++;
        checks++; if (io_miss_count !== 32'd0) $display("FAIL fill_miss: got %0d expected 0", io_miss_count); else passed++;
        checks++; if (io_dup_count !== 32'd0) $display("FAIL fill_dup: got %0d expected 0", io_dup_count); else passed++;
        checks++; if (io_cycles !== 64'd64) $display("FAIL fill_cycles: got %0d expected 64", io_cycles); else passed++;
        checks++; if (io_ready !== 1'b0) $display("FAIL fill_ready_done: got %0d expected 0", io_ready); else passed++;
        io_rdAddr = 32'd5;
        tick();
        checks++; if (io_rdData !== 32'h3F800005) $display("FAIL fill_rd5: got %h expected 3f800005", io_rdData); else passed++;
        io_rdAddr = 32'd63;
        tick();
        checks++; if (io_rdData !== 32'h3F80003F) $display("FAIL fill_rd63: got %h expected 3f80003f", io_rdData); else passed++;
        tick();
        checks++; if (io_cycles !== 64'd64) $display("FAIL fill_cycles_frozen: got %0d expected 64", io_cycles); else passed++;
    endtask

    task automatic test_dup();
        apply_reset();
        set_push(32'd3, MISS_T, 1'b0);
        tick();
        set_push(32'd3, 32'h40000000, 1'b0);
        tick();
        checks++; if (io_miss_count !== 32'd1) $display("FAIL dup_miss_first: got %0d expected 1", io_miss_count); else passed++;
        set_push(32'd3, 32'h40400000, 1'b1);
        tick();
        clear_inputs();
        tick();
        tick();
        checks++; if (io_done !== 1'b1) $display("FAIL dup_done: got %0d expected 1", io_done); else passed++;
        checks++; if (io_ray_count !== 32'd1) $display("FAIL dup_ray: got %0d expected 1", io_ray_count); else passed++;
        checks++; if (io_dup_count !== 32'd2) $display("FAIL dup_dup: got %0d expected 2", io_dup_count); else passed++;
        checks++; if (io_miss_count !== 32'd0) $display("FAIL dup_miss: got %0d expected 0", io_miss_count); else passed++;
        io_rdAddr = 32'd3;
        tick();
        checks++; if (io_rdData !== 32'h40000000) $display("FAIL dup_rd3: got %h expected 40000000", io_rdData); else passed++;
    endtask

    task automatic test_oob();
        apply_reset();
        set_push(32'd70, 32'h3F000000, 1'b0);
        tick();
        set_push(32'd1, 32'h3F000001, 1'b1);
        tick();
        clear_inputs();
        tick();
        tick();
        checks++; if (io_err_oob !== 1'b1) $display("FAIL oob_flag: got %0d expected 1", io_err_oob); else passed++;
        checks++; if (io_ray_count !== 32'd1) $display("FAIL oob_ray: got %0d expected 1", io_ray_count); else passed++;
        io_rdAddr = 32'd70;
        tick();
        checks++; if (io_rdData !== MISS_T) $display("FAIL oob_rd70: got %h expected %h", io_rdData, MISS_T); else passed++;
        io_rdAddr = 32'd6;
        tick();
        checks++; if (io_rdData !== MISS_T) $display("FAIL oob_rd6_alias: got %h expected %h", io_rdData, MISS_T); else passed++;
        io_rdAddr = 32'd1;
        tick();
        checks++; if (io_rdData !== 32'h3F000001) $display("FAIL oob_rd1: got %h expected 3f000001", io_rdData); else passed++;
    endtask

    task automatic test_no_results();
        apply_reset();
        io_rtp_finish = 1'b1;
        tick();
        io_rtp_finish = 1'b0;
        tick();
        checks++; if (io_done !== 1'b1) $display("FAIL empty_done: got %0d expected 1", io_done); else passed++;
        checks++; if (io_ray_count !== 32'd0) $display("FAIL empty_ray: got %0d expected 0", io_ray_count); else passed++;
        checks++; if (io_miss_count !== 32'd0) $display("FAIL empty_miss: got %0d expected 0", io_miss_count); else passed++;
        checks++; if (io_dup_count !== 32'd0) $display("FAIL empty_dup: got %0d expected 0", io_dup_count); else passed++;
        checks++; if (io_cycles !== 64'd1) $display("FAIL empty_cycles: got %0d expected 1", io_cycles); else passed++;
        // A push attempt and another finish in DONE must change nothing.
        set_push(32'd2, 32'h3F000000, 1'b1);
        tick();
        clear_inputs();
        tick();
        checks++; if (io_ray_count !== 32'd0) $display("FAIL done_push_ignored: got %0d expected 0", io_ray_count); else passed++;
        checks++; if (io_done !== 1'b1) $display("FAIL done_hold: got %0d expected 1", io_done); else passed++;
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int id = 0; id < 10; id++) begin
            set_push(32'(id), 32'h3F800000 + 32'(id), 1'b0);
            tick();
        end
        set_push(32'd10, 32'h3F80000A, 1'b0);
        reset = 1'b1;
        tick();
        checks++; if (io_ray_count !== 32'd0) $display("FAIL mid_rst_ray: got %0d expected 0", io_ray_count); else passed++;
        checks++; if (io_cycles !== 64'd0) $display("FAIL mid_rst_cycles: got %0d expected 0", io_cycles); else passed++;
        checks++; if (io_rdData !== MISS_T) $display("FAIL mid_rst_rddata: got %h expected %h", io_rdData, MISS_T); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL mid_rst_state: got %0d expected 0", dbg_state); else passed++;
        checks++; if (io_ready !== 1'b1) $display("FAIL mid_rst_ready: got %0d expected 1", io_ready); else passed++;
        reset = 1'b0;
        for (int id = 20; id < 23; id++) begin
            set_push(32'(id), 32'h40A00000 + 32'(id), id == 22);
            tick();
        end
        clear_inputs();
        tick();
        checks++; if (io_done !== 1'b1) $display("FAIL mid_done: got %0d expected 1", io_done); else passed++;
        checks++; if (io_ray_count !== 32'd3) $display("FAIL mid_ray: got %0d expected 3", io_ray_count); else passed++;
        checks++; if (io_cycles !== 64'd3) $display("FAIL mid_cycles: got %0d expected 3", io_cycles); else passed++;
        io_rdAddr = 32'd5;
        tick();
        checks++; if (io_rdData !== MISS_T) $display("FAIL mid_rd5_cleared: got %h expected %h", io_rdData, MISS_T); else passed++;
        io_rdAddr = 32'd21;
        tick();
        checks++; if (io_rdData !== 32'h40A00015) $display("FAIL mid_rd21: got %h expected 40a00015", io_rdData); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_dup();
        test_oob();
        test_no_results();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
